// File: rtl/i2c_lcd_top.sv
// Temperature/humidity display: HD44780 16x2 LCD behind a PCF8574 backpack, driven by a bit-level I2C master.
// Optional build macro I2C_ACK_CHECK_EN: a NACK issues STOP and restarts the whole power-up/init sequence.
module i2c_lcd_top #(
  parameter int         CLK_FREQ       = 100_000_000,
  parameter int         I2C_FREQ       = 100_000,
  parameter logic [6:0] LCD_ADDR       = 7'h27,
  parameter int         POWERUP_CYCLES = 5_000_000,
  parameter int         CMD_CYCLES     = 200_000,
  parameter int         REFRESH_CYCLES = 10_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] temperature,
  input  logic [7:0] humidity,
  output wire        scl,
  inout  wire        sda
);
  localparam int QP = CLK_FREQ / (4 * I2C_FREQ);
`ifdef I2C_ACK_CHECK_EN
  localparam bit ACK_CHK = 1'b1;
`else
  localparam bit ACK_CHK = 1'b0;
`endif

  typedef enum logic [2:0] {PWRUP, START, BITS, STOP, GAP, CMDW, REFR} state_t;

  state_t      st_q, st_d;
  logic [31:0] cnt_q, cnt_d;
  logic [1:0]  qtr_q, qtr_d, nib_q, nib_d;
  logic [4:0]  bit_q, bit_d;
  logic [3:0]  byte_q, byte_d;
  logic        init_q, init_d, nack_q, nack_d;
  logic        scl_lo_q, scl_lo_d, sda_lo_q, sda_lo_d;
  logic [6:0]  t_q, t_d, h_q, h_d;
  logic [7:0]  lcd_byte, exp_byte;
  logic [17:0] tx;
  logic        rs, qp_end, last_byte, go_frame;

  // Lines are only ever pulled low; a released line floats to the external pull-up.
  assign scl = scl_lo_q ? 1'b0 : 1'bz;
  assign sda = sda_lo_q ? 1'b0 : 1'bz;

  function automatic logic [6:0] sat99(input logic [7:0] x);
    return (x > 8'd99) ? 7'd99 : x[6:0];
  endfunction

  function automatic logic [7:0] dig(input logic [6:0] v, input logic tens);
    return 8'h30 + (tens ? 8'(v / 7'd10) : 8'(v % 7'd10));
  endfunction

  always_comb begin
    lcd_byte = 8'h00;
    rs       = 1'b1;
    if (init_q) begin
      rs = 1'b0;
      case (byte_q)
        4'd0:    lcd_byte = 8'h33;
        4'd1:    lcd_byte = 8'h32;
        4'd2:    lcd_byte = 8'h28;
        4'd3:    lcd_byte = 8'h0C;
        4'd4:    lcd_byte = 8'h06;
        default: lcd_byte = 8'h01;
      endcase
    end else begin
      case (byte_q)
        4'd0:    begin lcd_byte = 8'h80; rs = 1'b0; end
        4'd1:    lcd_byte = 8'h54;
        4'd2:    lcd_byte = 8'h3A;
        4'd3:    lcd_byte = dig(t_q, 1'b1);
        4'd4:    lcd_byte = dig(t_q, 1'b0);
        4'd5:    lcd_byte = 8'h20;
        4'd6:    lcd_byte = 8'h43;
        4'd7:    begin lcd_byte = 8'hC0; rs = 1'b0; end
        4'd8:    lcd_byte = 8'h48;
        4'd9:    lcd_byte = 8'h3A;
        4'd10:   lcd_byte = dig(h_q, 1'b1);
        4'd11:   lcd_byte = dig(h_q, 1'b0);
        4'd12:   lcd_byte = 8'h20;
        default: lcd_byte = 8'h25;
      endcase
    end
  end

  // nib_q: 0/1 = high nibble EN pulse high/low, 2/3 = low nibble; backlight always on.
  assign exp_byte  = {(nib_q[1] ? lcd_byte[3:0] : lcd_byte[7:4]), 1'b1, ~nib_q[0], 1'b0, rs};
  // A '1' bit (including both ACK slots) means "release sda".
  assign tx        = {LCD_ADDR, 1'b0, 1'b1, exp_byte, 1'b1};
  assign qp_end    = (cnt_q == 32'(QP - 1));
  assign last_byte = init_q ? (byte_q == 4'd5) : (byte_q == 4'd13);

  always_comb begin
    st_d = st_q; cnt_d = cnt_q + 32'd1; qtr_d = qtr_q; nib_d = nib_q; bit_d = bit_q;
    byte_d = byte_q; init_d = init_q; nack_d = nack_q; scl_lo_d = scl_lo_q; sda_lo_d = sda_lo_q;
    t_d = t_q; h_d = h_q; go_frame = 1'b0;
    case (st_q)
      PWRUP: if (cnt_q == 32'(POWERUP_CYCLES - 1)) begin
        st_d = START; cnt_d = '0; init_d = 1'b1; byte_d = '0; nib_d = '0; nack_d = 1'b0; sda_lo_d = 1'b1;
      end
      START: if (qp_end) begin
        st_d = BITS; cnt_d = '0; qtr_d = '0; bit_d = '0; scl_lo_d = 1'b1; sda_lo_d = ~tx[17];
      end
      BITS: if (qp_end) begin
        cnt_d = '0;
        qtr_d = qtr_q + 2'd1;
        case (qtr_q)
          2'd0: scl_lo_d = 1'b0;
          2'd1: if (bit_q == 5'd8 || bit_q == 5'd17) nack_d = nack_q | (ACK_CHK & sda);
          2'd2: scl_lo_d = 1'b1;
          default:
            if (bit_q == 5'd17 || nack_q) begin
              st_d = STOP; sda_lo_d = 1'b1;
            end else begin
              bit_d = bit_q + 5'd1; sda_lo_d = ~tx[5'd16 - bit_q];
            end
        endcase
      end
      STOP: if (qp_end) begin
        cnt_d = '0;
        if (qtr_q == 2'd0) begin
          qtr_d = 2'd1; scl_lo_d = 1'b0;
        end else begin
          qtr_d = 2'd0; sda_lo_d = 1'b0; st_d = GAP;
        end
      end
      GAP: if (cnt_q == 32'(4 * QP - 1)) begin
        cnt_d = '0;
        if (nack_q) st_d = PWRUP;
        else if (nib_q != 2'd3) begin
          nib_d = nib_q + 2'd1; st_d = START; sda_lo_d = 1'b1;
        end else begin
          nib_d = '0; st_d = CMDW;
        end
      end
      CMDW: if (cnt_q == 32'(CMD_CYCLES - 1)) begin
        cnt_d = '0;
        if (!last_byte) begin
          byte_d = byte_q + 4'd1; st_d = START; sda_lo_d = 1'b1;
        end else if (init_q) go_frame = 1'b1;
        else st_d = REFR;
      end
      REFR: if (cnt_q == 32'(REFRESH_CYCLES - 1)) go_frame = 1'b1;
      default: st_d = PWRUP;
    endcase
    // Readings are frozen here so a frame never mixes old and new values.
    if (go_frame) begin
      cnt_d = '0; init_d = 1'b0; byte_d = '0; st_d = START; sda_lo_d = 1'b1;
      t_d = sat99(temperature); h_d = sat99(humidity);
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      st_q <= PWRUP; cnt_q <= '0; qtr_q <= '0; nib_q <= '0; bit_q <= '0; byte_q <= '0;
      init_q <= 1'b0; nack_q <= 1'b0; scl_lo_q <= 1'b0; sda_lo_q <= 1'b0; t_q <= '0; h_q <= '0;
    end else begin
      st_q <= st_d; cnt_q <= cnt_d; qtr_q <= qtr_d; nib_q <= nib_d; bit_q <= bit_d; byte_q <= byte_d;
      init_q <= init_d; nack_q <= nack_d; scl_lo_q <= scl_lo_d; sda_lo_q <= sda_lo_d; t_q <= t_d; h_q <= h_d;
    end
  end
endmodule

// File: tb/tb_i2c_lcd_top.sv
// Bench for i2c_lcd_top: bus monitor decodes I2C transactions and checks them against an LCD-level model queue.
module tb_i2c_lcd_top;
  localparam int PWR = 10, CMDC = 20, REFC = 200, QP = 2;
  localparam int GAPB = 4 * QP;
  localparam int G_BYTE = GAPB + CMDC;
  localparam int G_REFR = GAPB + CMDC + REFC;

  logic clk = 1'b0, rst = 1'b1;
  logic [7:0] temp, hum;
  wire scl_w, sda_w;
  pullup (scl_w);
  pullup (sda_w);

  i2c_lcd_top #(.CLK_FREQ(800), .I2C_FREQ(100), .LCD_ADDR(7'h27), .POWERUP_CYCLES(PWR),
                .CMD_CYCLES(CMDC), .REFRESH_CYCLES(REFC))
    dut (.clk(clk), .rst_n(rst), .temperature(temp), .humidity(hum), .scl(scl_w), .sda(sda_w));

  always #5 clk = ~clk;

  typedef struct {logic [7:0] d; int gap;} exp_t;
  exp_t       expq[$];
  logic [7:0] tlog[$];
  int n_vec = 0, n_err = 0, cyc = 0, starts = 0, stops = 0;
  int t_start = 0, t_stop = -1, bits = 0, cur_gap = -1;
  logic ps = 1'b1, pd = 1'b1;
  logic [18:0] sh = '0;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] want);
    n_vec++;
    if (got !== want) begin n_err++; $display("FAIL %s: got %h want %h", nm, got, want); end
  endtask

  task automatic chk_log(input int idx, input logic [7:0] want);
    n_vec++;
    if (idx >= tlog.size()) begin
      n_err++; $display("FAIL log[%0d]: only %0d txns captured, want %h", idx, tlog.size(), want);
    end else if (tlog[idx] !== want) begin
      n_err++; $display("FAIL log[%0d]: got %h want %h", idx, tlog[idx], want);
    end
  endtask

  task automatic check_txn(input logic [7:0] a, input logic [7:0] d, input int g);
    exp_t e;
    tlog.push_back(d);
    chk("addr_byte", a, 8'h4E);
    if (expq.size() == 0) begin
      n_vec++; n_err++; $display("FAIL extra_txn: got data %h, want no transaction", d);
    end else begin
      e = expq.pop_front();
      n_vec++;
      if (d !== e.d) begin n_err++; $display("FAIL data_byte[%0d]: got %h want %h", tlog.size() - 1, d, e.d); end
      if (e.gap >= 0) begin
        n_vec++;
        if (g != e.gap) begin n_err++; $display("FAIL idle_gap[%0d]: got %0d want %0d", tlog.size() - 1, g, e.gap); end
      end
    end
  endtask

  // Bus monitor: START/STOP from sda edges while scl high, bits on scl rising edges.
  always @(negedge clk) begin
    if (ps && scl_w && pd && !sda_w) begin
      starts++; bits = 0; sh = '0;
      cur_gap = (t_stop < 0) ? -1 : cyc - t_stop;
      t_start = cyc;
    end else if (ps && scl_w && !pd && sda_w) begin
      stops++; t_stop = cyc;
      if (bits == 19) check_txn(sh[18:11], sh[9:2], cur_gap);
      else begin n_vec++; n_err++; $display("FAIL stop_framing: got %0d scl pulses want 19", bits); end
    end else if (!ps && scl_w) begin
      bits++; sh = {sh[17:0], sda_w};
    end
    ps = scl_w; pd = sda_w;
  end

  // Model: each LCD byte becomes four expander writes, EN high then low, per nibble.
  task automatic push_lcd(input logic [7:0] b, input logic rs, input int g0);
    exp_t e;
    logic [3:0] nib;
    for (int k = 0; k < 4; k++) begin
      nib   = (k < 2) ? b[7:4] : b[3:0];
      e.d   = {nib, 1'b1, (k % 2 == 0), 1'b0, rs};
      e.gap = (k == 0) ? g0 : GAPB;
      expq.push_back(e);
    end
  endtask

  task automatic push_init(input int g0);
    logic [7:0] c[6];
    c = '{8'h33, 8'h32, 8'h28, 8'h0C, 8'h06, 8'h01};
    for (int i = 0; i < 6; i++) push_lcd(c[i], 1'b0, (i == 0) ? g0 : G_BYTE);
  endtask

  task automatic push_frame(input int t, input int h, input int g0);
    int tv, hv;
    logic [7:0] f[14];
    tv = (t > 99) ? 99 : t;
    hv = (h > 99) ? 99 : h;
    f = '{8'h80, 8'h54, 8'h3A, 8'(48 + tv / 10), 8'(48 + tv % 10), 8'h20, 8'h43,
          8'hC0, 8'h48, 8'h3A, 8'(48 + hv / 10), 8'(48 + hv % 10), 8'h20, 8'h25};
    for (int i = 0; i < 14; i++) push_lcd(f[i], !(i == 0 || i == 7), (i == 0) ? g0 : G_BYTE);
  endtask

  task automatic wait_size(input string nm, input int sz, input int budget);
    int n = 0;
    while (expq.size() > sz && n < budget) begin @(negedge clk); n++; end
    n_vec++;
    if (expq.size() > sz) begin
      n_err++; $display("FAIL %s_timeout: %0d txns outstanding want <= %0d", nm, expq.size(), sz);
      expq.delete();
    end
  endtask

  task automatic check_first_start(input string nm);
    int s0 = starts, r0 = cyc, n = 0;
    logic quiet = 1'b1;
    while (starts == s0 && n < 100) begin
      @(negedge clk); n++;
      if (n < PWR - 2) quiet = quiet & scl_w & sda_w;
    end
    chk({nm, "_quiet"}, {7'd0, quiet}, 8'd1);
    n_vec++;
    if (starts == s0 || (t_start - r0) < PWR - 1 || (t_start - r0) > PWR + 2) begin
      n_err++; $display("FAIL %s_start_delay: got %0d clocks want about %0d", nm, t_start - r0, PWR);
    end
  endtask

  initial begin
    int s0, n;
    temp = 8'd25; hum = 8'd60; rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_scl", {7'd0, scl_w}, 8'd1);
    chk("rst_sda", {7'd0, sda_w}, 8'd1);
    push_init(-1);
    push_frame(25, 60, G_BYTE);
    @(negedge clk); rst = 1'b0;
    check_first_start("pwrup");
    wait_size("init_f1", 0, 20000);
    chk_log(0, 8'h3C); chk_log(1, 8'h38); chk_log(2, 8'h3C); chk_log(3, 8'h38);
    chk_log(28, 8'h5D); chk_log(29, 8'h59); chk_log(30, 8'h4D); chk_log(31, 8'h49);
    chk_log(38, 8'h2D);

    temp = 8'd0; hum = 8'd0; push_frame(0, 0, G_REFR);
    wait_size("f_zero", 0, 12000);
    chk_log(94, 8'h0D);
    temp = 8'd99; hum = 8'd99; push_frame(99, 99, G_REFR);
    wait_size("f_99", 0, 12000);
    chk_log(150, 8'h9D);
    temp = 8'd200; hum = 8'd150; push_frame(200, 150, G_REFR);
    wait_size("f_sat", 0, 12000);
    chk_log(204, 8'h3D); chk_log(206, 8'h9D);

    temp = 8'd40; hum = 8'd90; push_frame(40, 90, G_REFR);
    wait_size("f_mid", 30, 12000);
    temp = 8'd10; hum = 8'd20; push_frame(10, 20, G_REFR);
    wait_size("f_next", 0, 24000);
    chk_log(262, 8'h4D); chk_log(318, 8'h1D);

    push_frame(10, 20, G_REFR);
    wait_size("f_pre_rst", 40, 12000);
    n = 0;
    do begin @(negedge clk); n++; end while ((scl_w || sda_w) && n < 200);
    chk("mid_low_found", {7'd0, scl_w | sda_w}, 8'd0);
    #1 rst = 1'b1;
    #1;
    chk("abort_scl", {7'd0, scl_w}, 8'd1);
    chk("abort_sda", {7'd0, sda_w}, 8'd1);
    s0 = stops;
    repeat (5) @(negedge clk);
    n_vec++;
    if (stops != s0) begin n_err++; $display("FAIL abort_no_stop: got %0d stops want 0", stops - s0); end
    expq.delete();
    t_stop = -1;
    push_init(-1);
    rst = 1'b0;
    check_first_start("restart");
    wait_size("reinit", 0, 6000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/i2c_lcd_top.md
Name: i2c_lcd_top

Overview:
- Display-side top of the cold-storage controller.
- Takes 8-bit temperature and humidity readings and shows them on a 16x2 HD44780 character LCD.
- The LCD sits behind a PCF8574 I2C backpack.
- Contains a bit-level I2C master plus a sequencer for LCD init and periodic refresh. Only pins are scl and open-drain sda.

Parameters:
- CLK_FREQ, 100_000_000: system clock frequency in Hz.
- I2C_FREQ, 100_000: SCL frequency in Hz. Quarter-period QP = CLK_FREQ/(4*I2C_FREQ) clocks (250 at defaults).
- LCD_ADDR, 7'h27: PCF8574 7-bit slave address. Address byte = {LCD_ADDR,1'b0} = 8'h4E.
- POWERUP_CYCLES, 5_000_000: wait after reset before the first transfer (50 ms).
- CMD_CYCLES, 200_000: wait after every LCD command or character (2 ms).
- REFRESH_CYCLES, 10_000_000: idle between display frames (100 ms).

Ports:
- clk, input, 1: system clock; all logic on rising edge.
- rst_n, input, 1: asynchronous, active-high reset (1 = reset). Name kept per codebase convention; polarity is high.
- temperature, input, 8: temperature in degrees C, unsigned.
- humidity, input, 8: relative humidity in %, unsigned.
- scl, output, 1: I2C clock. Driven 0 or released as 1'bz; external pull-up.
- sda, inout, 1: I2C data, open-drain. Driven 0 or 1'bz; read back for ACK.

Behaviour:
- Reset (async):
  - scl and sda released (z); all counters cleared.
  - Sequencer goes to PWRUP. Reset mid-transfer aborts immediately with no STOP generated.
- Sequencer states:
  - PWRUP: wait POWERUP_CYCLES, then INIT.
  - INIT: send commands 0x33, 0x32, 0x28, 0x0C, 0x06, 0x01, each followed by a CMD_CYCLES wait. Then FRAME.
  - FRAME: latch temperature and humidity in the same clock, then send this byte list:
    - 0x80 (cmd)
    - 'T', ':', Td1, Td0, ' ', 'C'
    - 0xC0 (cmd)
    - 'H', ':', Hd1, Hd0, ' ', '%'
    - Each byte followed by a CMD_CYCLES wait. Then REFRESH.
  - REFRESH: wait REFRESH_CYCLES, then FRAME. Loops forever.
- Digits:
  - Saturate: v = (x > 99) ? 99 : x.
  - d1 = v/10, d0 = v%10. Each sent as ASCII 0x30+d.
  - Input changes during a frame do not affect that frame.
- LCD byte to PCF8574:
  - Expander bits: P0 = RS (0 cmd, 1 char), P1 = RW = 0, P2 = EN, P3 = backlight = 1, P7..P4 = nibble.
  - One LCD byte = four I2C write transactions, in order: {hi,1,1,0,RS}, {hi,0,1,0,RS}, {lo,1,1,0,RS}, {lo,0,1,0,RS}.
- I2C transaction:
  - START, address byte 0x4E, ACK slot, data byte, ACK slot, STOP.
  - Idle gap of 4*QP clocks between transactions.
- I2C timing (in units of QP):
  - START: sda falls while scl released; scl falls 1 QP later.
  - Each bit occupies 4 QP: data changes in QP0 with scl low; scl released at QP1; held through QP2; low at QP3. MSB first.
  - ACK slot: sda released; sda sampled at middle of scl high.
  - STOP: sda low, scl released, then sda released 1 QP later.
- ACK handling: ACK value ignored by default (see Optional Feature).
- Quiet lines: scl and sda never driven high. Both released whenever the bus is idle.

Optional Feature:
- Macro: I2C_ACK_CHECK_EN.
- With it defined: a NACK on either ACK slot finishes the current bit, issues STOP, discards the rest of the LCD byte, and returns the sequencer to PWRUP for full re-init.
- Without it: ACK is sampled but ignored; the sequence never stalls or restarts.

Test Plan:
- Reset, then release, with POWERUP_CYCLES=10, CMD_CYCLES=20, QP=2 -> scl/sda = z during reset and the wait. First START (sda low while scl high) occurs ~10 clocks after reset release. First data byte is 0x3C (0x33 hi nibble, EN=1, BL=1).
- Capture all INIT transactions with a bus monitor -> address byte 0x4E every time. Data bytes 3C,38,3C,38 for command 0x33, and the six commands appear in order.
- temperature=25, humidity=60 -> frame decodes to line1 "T:25 C" at 0x80 and line2 "H:60 %" at 0xC0. Characters sent with RS=1 (e.g. 'T' = 0x5D,0x59,0x4D,0x49).
- temperature=0/humidity=0 -> "T:00 C"/"H:00 %". temperature=99/humidity=99 -> "99". temperature=200 -> "T:99 C" (saturated).
- Change inputs mid-frame (40/90 to 10/20) -> current frame shows 40/90; next frame after REFRESH shows 10/20.
- Assert rst_n mid-transfer -> scl/sda released within the same cycle, no STOP issued, and sequence restarts with PWRUP then INIT. With I2C_ACK_CHECK_EN and no slave pull-down (NACK) -> STOP follows the address byte and PWRUP re-entered.
